alu_stim_checker: RTL
=====================

// Module: alu_stim_checker
// PURPOSE
//  Hardware initiator for the user ALU partitions (user1..user4). It replaces the PS GPIO path:
//  drives A/B/ALUop, waits for the combinational ALU to settle, captures Result/flags, and checks
//  them against an internal golden model. Error/pass counters are read back over GPIO.
// PARAMETERS
//  DATA_WIDTH     32  operand/result width
//  SETTLE_CYCLES  2   wait cycles between driving operands and sampling (1..15)
//  CNT_WIDTH      16  width of num_vectors, counters and index
// PORTS
//  clk          in   1           single clock
//  resetn       in   1           asynchronous, active-low reset
//  start        in   1           1-cycle request; accepted only in IDLE/DONE
//  abort        in   1           synchronous; returns the FSM to IDLE
//  seed         in   DATA_WIDTH  LFSR seed; sampled on an accepted start
//  num_vectors  in   CNT_WIDTH   vectors per run; sampled on an accepted start
//  alu_A        out  DATA_WIDTH  operand A to the ALU
//  alu_B        out  DATA_WIDTH  operand B to the ALU
//  alu_op       out  3           ALUop to the ALU
//  Result       in   DATA_WIDTH  ALU result
//  Overflow     in   1           ALU overflow flag
//  CarryOut     in   1           ALU carry flag
//  Zero         in   1           ALU zero flag
//  busy         out  1           run in progress
//  done         out  1           level; set at run end, cleared by the next accepted start/abort
//  pass_count   out  CNT_WIDTH   vectors matching the golden model
//  err_count    out  CNT_WIDTH   mismatching vectors; saturates at all-ones
//  fail_index   out  CNT_WIDTH   index of the first failing vector
//  fail_valid   out  1           fail_index holds a valid value
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, LFSR = 1.
//  Ops: AND=000, OR=001, ADD=010, SUB=110, SLT=111. Vector i uses op_table[i mod 5] in that order.
//  Stimulus: 32-bit Galois LFSR, polynomial 0x80200003. A = state after one step, B = state after
//    the next step (two steps per vector). A seed of 0 is replaced by 1.
//  Golden model:
//    ADD: carry = bit DATA_WIDTH of the unsigned sum.
//    SUB: CarryOut = (A < B) unsigned; Result = A - B.
//    Overflow: signed overflow of ADD/SUB.
//    SLT: Result = {0.., $signed(A) < $signed(B)}.
//    Zero = (Result == 0) for all ops.
//    Overflow/CarryOut are compared for ADD/SUB only; they are masked for AND/OR/SLT.
//  FSM:
//    IDLE/DONE -start-> LOAD (sample seed/num_vectors, clear counters, fail_valid, done; busy=1).
//      If num_vectors == 0, go straight to DONE.
//    LOAD  -> DRIVE   register A/B/op onto the alu_* outputs (outputs are flops).
//    DRIVE -> SETTLE  count SETTLE_CYCLES.
//    SETTLE -> CHECK  compare the registered ALU outputs against the golden model; update one counter;
//      on the first error latch fail_index and set fail_valid.
//    CHECK -> DRIVE if index+1 < num_vectors, else DONE (busy=0, done=1).
//  Per-vector latency: 2 + SETTLE_CYCLES clocks (DRIVE + settle + CHECK).
//  alu_* outputs hold their last value in IDLE/DONE.
//  Simultaneous start and abort: abort wins -> IDLE, done=0, counters hold their values.
//  start while busy: ignored. num_vectors/seed changes mid-run: ignored.
//  Counter wrap: pass_count + err_count == num_vectors, so pass_count cannot wrap; err_count saturates.
//  resetn low mid-run: immediate return to reset values; no partial done.
// STRUCTURE
//  alu_pkg: ALUop localparams, op_table, LFSR polynomial, DATA_WIDTH default.
//  Sub-module alu_ref_model (combinational golden model: A, B, op -> Result, Overflow, CarryOut,
//    Zero, flag_mask). The LFSR and the FSM stay inline.
// TESTING (bench ALU model connected to alu_*; pass_count/err_count refer to the counters)
//  1. seed=1, num_vectors=10, correct ALU -> pass_count=10, err_count=0, done after 10*(2+2)+1 clocks.
//  2. ALU forced to ADD CarryOut=0; num_vectors=50 -> err_count = number of ADD vectors with a carry;
//     fail_index = first such index.
//  3. num_vectors=0 -> done=1 two cycles after start; counters 0; alu_* never toggle.
//  4. abort asserted in the SETTLE state of vector 3 -> busy=0, done=0, pass_count=3.
//     A new start then restarts from seed and the counts reset.
//  5. resetn pulsed low mid-run -> all outputs 0 asynchronously; LFSR = 1 after release.
//  6. Directed golden check via seed chosen so that A=0x7FFFFFFF, B=1 on an ADD vector
//     -> Overflow=1, Result=0x80000000 counted as a pass.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU stimulus checker.
//   - ALU operation encodings and the fixed five-entry op rotation
//   - Galois LFSR feedback polynomial
//   - FSM state encodings
package alu_pkg;

  localparam int ALU_DATA_WIDTH = 32;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_DRIVE  = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  // Vector i uses entry (i mod 5) of this rotation.
  function automatic logic [2:0] op_of_sel(input logic [2:0] sel);
    logic [2:0] op;
    case (sel)
      3'd0:    op = OP_AND;
      3'd1:    op = OP_OR;
      3'd2:    op = OP_ADD;
      3'd3:    op = OP_SUB;
      3'd4:    op = OP_SLT;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the user ALU.
// Ports:
//   i_a, i_b      operands
//   i_op          ALUop
//   o_result      expected result
//   o_overflow    signed overflow (ADD/SUB)
//   o_carry_out   ADD: carry out of the MSB; SUB: unsigned borrow (A < B)
//   o_zero        result is all zeros
//   o_flag_mask   1 when Overflow/CarryOut are meaningful (ADD/SUB only)
module alu_ref_model
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic [2:0]            i_op,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_overflow,
  output logic                  o_carry_out,
  output logic                  o_zero,
  output logic                  o_flag_mask
);

  localparam int MSB = DATA_WIDTH - 1;

  logic [DATA_WIDTH:0]   w_sum;
  logic [DATA_WIDTH-1:0] w_diff;
  logic                  w_slt;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = i_a - i_b;
  assign w_slt  = $signed(i_a) < $signed(i_b);

  always_comb begin
    o_result    = '0;
    o_overflow  = 1'b0;
    o_carry_out = 1'b0;
    o_flag_mask = 1'b0;
    case (i_op)
      OP_AND: o_result = i_a & i_b;
      OP_OR:  o_result = i_a | i_b;
      OP_ADD: begin
        o_result    = w_sum[MSB:0];
        o_carry_out = w_sum[DATA_WIDTH];
        // Same-sign operands producing a result of the other sign.
        o_overflow  = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
        o_flag_mask = 1'b1;
      end
      OP_SUB: begin
        o_result    = w_diff;
        o_carry_out = i_a < i_b;
        // Opposite-sign operands where the result sign differs from A.
        o_overflow  = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);
        o_flag_mask = 1'b1;
      end
      OP_SLT: o_result = {{(DATA_WIDTH-1){1'b0}}, w_slt};
      default: o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/alu_stim_checker.sv
// Hardware initiator/checker for the user ALU partitions.
// Drives LFSR-generated operands and a rotating ALUop onto the ALU, waits for
// it to settle, captures its outputs and compares them against alu_ref_model.
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   start, abort                run request (IDLE/DONE only), synchronous abort
//   seed, num_vectors           run configuration, sampled on an accepted start
//   alu_A, alu_B, alu_op        registered stimulus to the ALU
//   Result, Overflow,
//   CarryOut, Zero              ALU response
//   busy, done                  run in progress / run finished (level)
//   pass_count, err_count       matching / mismatching vectors (err saturates)
//   fail_index, fail_valid      first failing vector index
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start
// S_LOAD   | configuration sampled, counters cleared
// S_DRIVE  | new operands on alu_* this cycle
// S_SETTLE | waiting SETTLE_CYCLES for the combinational ALU
// S_CHECK  | compare captured ALU outputs, update counters
// S_DONE   | run finished, done held high
module alu_stim_checker
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = ALU_DATA_WIDTH,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic [CNT_WIDTH-1:0]  num_vectors,
  output logic [DATA_WIDTH-1:0] alu_A,
  output logic [DATA_WIDTH-1:0] alu_B,
  output logic [2:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] Result,
  input  logic                  Overflow,
  input  logic                  CarryOut,
  input  logic                  Zero,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  pass_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [CNT_WIDTH-1:0]  fail_index,
  output logic                  fail_valid
);

  logic [2:0]            r_state;
  logic [DATA_WIDTH-1:0] r_lfsr;
  logic [DATA_WIDTH-1:0] r_alu_a;
  logic [DATA_WIDTH-1:0] r_alu_b;
  logic [2:0]            r_alu_op;
  logic [2:0]            r_op_sel;
  logic [CNT_WIDTH-1:0]  r_nv;
  logic [CNT_WIDTH-1:0]  r_idx;
  logic [CNT_WIDTH-1:0]  r_pass;
  logic [CNT_WIDTH-1:0]  r_err;
  logic [CNT_WIDTH-1:0]  r_fail_idx;
  logic                  r_fail_valid;
  logic [3:0]            r_settle;
  logic [DATA_WIDTH-1:0] r_res;
  logic                  r_ovf;
  logic                  r_cout;
  logic                  r_zero;

  logic [DATA_WIDTH-1:0] w_poly;
  logic [DATA_WIDTH-1:0] w_step_a;
  logic [DATA_WIDTH-1:0] w_step_b;
  logic [2:0]            w_sel_use;
  logic [CNT_WIDTH:0]    w_idx_nxt;
  logic                  w_last;
  logic                  w_match;
  logic [DATA_WIDTH-1:0] w_ref_res;
  logic                  w_ref_ovf;
  logic                  w_ref_cout;
  logic                  w_ref_zero;
  logic                  w_ref_mask;

  alu_ref_model #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ref (
    .i_a         (r_alu_a),
    .i_b         (r_alu_b),
    .i_op        (r_alu_op),
    .o_result    (w_ref_res),
    .o_overflow  (w_ref_ovf),
    .o_carry_out (w_ref_cout),
    .o_zero      (w_ref_zero),
    .o_flag_mask (w_ref_mask)
  );

  // Two Galois steps per vector: A is one step ahead, B two steps ahead.
  assign w_poly   = DATA_WIDTH'(LFSR_POLY);
  assign w_step_a = (r_lfsr >> 1) ^ (r_lfsr[0] ? w_poly : '0);
  assign w_step_b = (w_step_a >> 1) ^ (w_step_a[0] ? w_poly : '0);

  // From LOAD the rotation starts at entry 0; from CHECK it advances mod 5.
  assign w_sel_use = (r_state == S_CHECK) ?
                     ((r_op_sel == 3'd4) ? 3'd0 : r_op_sel + 3'd1) : r_op_sel;

  assign w_idx_nxt = {1'b0, r_idx} + {{CNT_WIDTH{1'b0}}, 1'b1};
  assign w_last    = w_idx_nxt >= {1'b0, r_nv};

  assign w_match = (r_res == w_ref_res) && (r_zero == w_ref_zero) &&
                   (!w_ref_mask || ((r_ovf == w_ref_ovf) && (r_cout == w_ref_cout)));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_lfsr       <= DATA_WIDTH'(1);
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= '0;
      r_op_sel     <= '0;
      r_nv         <= '0;
      r_idx        <= '0;
      r_pass       <= '0;
      r_err        <= '0;
      r_fail_idx   <= '0;
      r_fail_valid <= 1'b0;
      r_settle     <= '0;
      r_res        <= '0;
      r_ovf        <= 1'b0;
      r_cout       <= 1'b0;
      r_zero       <= 1'b0;
    end else begin
      r_res  <= Result;
      r_ovf  <= Overflow;
      r_cout <= CarryOut;
      r_zero <= Zero;

      if (abort) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (start) begin
              r_state      <= S_LOAD;
              r_lfsr       <= (seed == '0) ? DATA_WIDTH'(1) : seed;
              r_nv         <= num_vectors;
              r_idx        <= '0;
              r_op_sel     <= '0;
              r_pass       <= '0;
              r_err        <= '0;
              r_fail_idx   <= '0;
              r_fail_valid <= 1'b0;
            end
          end
          S_LOAD: begin
            if (r_nv == '0) begin
              r_state <= S_DONE;
            end else begin
              r_state  <= S_DRIVE;
              r_alu_a  <= w_step_a;
              r_alu_b  <= w_step_b;
              r_lfsr   <= w_step_b;
              r_op_sel <= w_sel_use;
              r_alu_op <= op_of_sel(w_sel_use);
            end
          end
          S_DRIVE: begin
            r_state  <= S_SETTLE;
            r_settle <= 4'(SETTLE_CYCLES - 1);
          end
          S_SETTLE: begin
            if (r_settle == 4'd0) r_state <= S_CHECK;
            else r_settle <= r_settle - 4'd1;
          end
          S_CHECK: begin
            if (w_match) begin
              r_pass <= r_pass + CNT_WIDTH'(1);
            end else begin
              if (r_err != '1) r_err <= r_err + CNT_WIDTH'(1);
              if (!r_fail_valid) begin
                r_fail_idx   <= r_idx;
                r_fail_valid <= 1'b1;
              end
            end
            if (w_last) begin
              r_state <= S_DONE;
            end else begin
              r_state  <= S_DRIVE;
              r_idx    <= w_idx_nxt[CNT_WIDTH-1:0];
              r_alu_a  <= w_step_a;
              r_alu_b  <= w_step_b;
              r_lfsr   <= w_step_b;
              r_op_sel <= w_sel_use;
              r_alu_op <= op_of_sel(w_sel_use);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign alu_A      = r_alu_a;
  assign alu_B      = r_alu_b;
  assign alu_op     = r_alu_op;
  assign busy       = (r_state == S_LOAD) || (r_state == S_DRIVE) ||
                      (r_state == S_SETTLE) || (r_state == S_CHECK);
  assign done       = (r_state == S_DONE);
  assign pass_count = r_pass;
  assign err_count  = r_err;
  assign fail_index = r_fail_idx;
  assign fail_valid = r_fail_valid;

endmodule
